// File: rtl/stock_code_lookup.sv
// Open-addressed stock-code table lookup with linear probing over an external 512x70 RAM.
// Host writes share the RAM port and take priority over lookups whenever the engine is idle.
//
// state | meaning
// IDLE  | ready for a lookup; a pending host write wins
// WAIT  | RAM read in flight for the current probe address
// CMP   | compare RAM entry against latched code, decide hit/miss/next probe
// RESP  | response held until rsp_ready
// WRITE | single-cycle host write to the RAM, ack pulsed
module stock_code_lookup #(
    parameter int MAX_PROBE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [47:0] req_code,
    input  logic [8:0]  req_hash,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_hit,
    output logic [20:0] rsp_data,
    output logic [8:0]  rsp_index,
    input  logic        host_wr_req,
    input  logic [8:0]  host_wr_addr,
    input  logic [69:0] host_wr_data,
    output logic        host_wr_ack,
    output logic [8:0]  mem_addr,
    output logic [69:0] mem_din,
    output logic        mem_we,
    input  logic [69:0] mem_dout
);

    typedef enum logic [2:0] {IDLE, WAIT, CMP, RESP, WRITE} state_t;

    localparam logic [2:0] LAST_PROBE = 3'(MAX_PROBE - 1);

    state_t      state;
    logic [47:0] code_q;
    logic [8:0]  hash_q;
    logic [2:0]  probe_q;

    logic        entry_valid;
    logic [47:0] entry_code;
    logic [20:0] entry_payload;
    logic [2:0]  probe_next;

    assign entry_valid   = mem_dout[69];
    assign entry_code    = mem_dout[68:21];
    assign entry_payload = mem_dout[20:0];
    assign probe_next    = probe_q + 3'd1;

    // Combinational so a write request arriving in IDLE blocks the same-cycle accept.
    assign req_ready = !reset && (state == IDLE) && !host_wr_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            code_q      <= '0;
            hash_q      <= '0;
            probe_q     <= '0;
            rsp_valid   <= 1'b0;
            rsp_hit     <= 1'b0;
            rsp_data    <= '0;
            rsp_index   <= '0;
            host_wr_ack <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
            mem_we      <= 1'b0;
        end else begin
            host_wr_ack <= 1'b0;
            mem_we      <= 1'b0;
            case (state)
                IDLE: begin
                    if (host_wr_req) begin
                        mem_we      <= 1'b1;
                        mem_addr    <= host_wr_addr;
                        mem_din     <= host_wr_data;
                        host_wr_ack <= 1'b1;
                        state       <= WRITE;
                    end else if (req_valid) begin
                        code_q   <= req_code;
                        hash_q   <= req_hash;
                        probe_q  <= '0;
                        mem_addr <= req_hash;
                        state    <= WAIT;
                    end
                end
                WAIT: state <= CMP;
                CMP: begin
                    if (entry_valid && (entry_code == code_q)) begin
                        rsp_valid <= 1'b1;
                        rsp_hit   <= 1'b1;
                        rsp_data  <= entry_payload;
                        rsp_index <= mem_addr;
                        state     <= RESP;
                    end else if (!entry_valid || (probe_q == LAST_PROBE)) begin
                        // Empty slot ends the chain; otherwise the probe budget is spent.
                        rsp_valid <= 1'b1;
                        rsp_hit   <= 1'b0;
                        rsp_data  <= '0;
                        rsp_index <= mem_addr;
                        state     <= RESP;
                    end else begin
                        probe_q  <= probe_next;
                        mem_addr <= hash_q + 9'(probe_next);
                        state    <= WAIT;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                WRITE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stock_code_lookup.sv
// Self-checking bench for stock_code_lookup: behavioural RAM plus a shadow-table lookup model.
module tb_stock_code_lookup;

    localparam int MAX_PROBE = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [47:0] req_code = '0;
    logic [8:0]  req_hash = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_hit;
    logic [20:0] rsp_data;
    logic [8:0]  rsp_index;
    logic        host_wr_req = 1'b0;
    logic [8:0]  host_wr_addr = '0;
    logic [69:0] host_wr_data = '0;
    logic        host_wr_ack;
    logic [8:0]  mem_addr;
    logic [69:0] mem_din;
    logic        mem_we;
    logic [69:0] mem_dout;

    logic [69:0] ram    [512];
    logic [69:0] shadow [512];

    int errors = 0;
    int checks = 0;

    localparam logic [47:0] AAPL = 48'h4141504C2020;
    localparam logic [47:0] MSFT = 48'h4D5346542020;
    localparam logic [47:0] GOOG = 48'h474F4F472020;
    localparam logic [47:0] IBM  = 48'h49424D202020;

    stock_code_lookup #(.MAX_PROBE(MAX_PROBE)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_code(req_code), .req_hash(req_hash),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_hit(rsp_hit), .rsp_data(rsp_data), .rsp_index(rsp_index),
        .host_wr_req(host_wr_req), .host_wr_addr(host_wr_addr),
        .host_wr_data(host_wr_data), .host_wr_ack(host_wr_ack),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    function automatic logic [69:0] mk(input logic v, input logic [47:0] c, input logic [20:0] p);
        return {v, c, p};
    endfunction

    // Reference: walk the shadow table from hash, stop on empty slot, match or probe budget.
    function automatic void model(input logic [47:0] code, input logic [8:0] hash,
                                  output logic hit, output logic [20:0] data,
                                  output logic [8:0] idx, output int lat);
        hit = 1'b0; data = '0;
        idx = 9'((int'(hash) + MAX_PROBE - 1) % 512);
        lat = 2 * MAX_PROBE + 1;
        for (int p = 0; p < MAX_PROBE; p++) begin
            int i;
            i = (int'(hash) + p) % 512;
            if (shadow[i][69] == 1'b0) begin
                idx = 9'(i); lat = 2 * (p + 1) + 1;
                return;
            end
            if (shadow[i][68:21] == code) begin
                hit = 1'b1; data = shadow[i][20:0]; idx = 9'(i); lat = 2 * (p + 1) + 1;
                return;
            end
        end
    endfunction

    task automatic host_write(input logic [8:0] addr, input logic [69:0] data);
        int n;
        host_wr_addr = addr; host_wr_data = data; host_wr_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!host_wr_ack && n < 20);
        checks++;
        if (!host_wr_ack || mem_we !== 1'b1 || mem_addr !== addr || mem_din !== data) begin
            errors++;
            $display("FAIL host_write addr=%0d: ack=%b we=%b mem_addr=%0d din=%h, want ack=1 we=1 addr=%0d din=%h",
                     addr, host_wr_ack, mem_we, mem_addr, mem_din, addr, data);
        end
        host_wr_req = 1'b0;
        shadow[addr] = data;
        @(negedge clk);
    endtask

    task automatic do_lookup(input logic [47:0] code, input logic [8:0] hash,
                             output logic hit, output logic [20:0] data,
                             output logic [8:0] idx, output int lat);
        int n;
        hit = 1'b0; data = '0; idx = '0; lat = -1;
        req_code = code; req_hash = hash; req_valid = 1'b1;
        #1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL lookup_accept_timeout: req_ready=%b, want 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk); lat++;
        end
        if (!rsp_valid) begin
            checks++; errors++;
            $display("FAIL lookup_rsp_timeout: rsp_valid=%b after %0d cycles, want 1", rsp_valid, lat);
            lat = -1;
            return;
        end
        hit = rsp_hit; data = rsp_data; idx = rsp_index;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_hit, rsp_data, rsp_index, host_wr_ack, mem_we, mem_addr, mem_din, req_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b hit=%b data=%h idx=%0d ack=%b we=%b addr=%0d din=%h ready=%b, want all 0",
                     rsp_valid, rsp_hit, rsp_data, rsp_index, host_wr_ack, mem_we, mem_addr, mem_din, req_ready);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: req_ready=%b, want 1", req_ready);
        end
    endtask

    task automatic test_basic_hit();
        logic h, eh; logic [20:0] d, ed; logic [8:0] i, ei; int l, el;
        host_write(9'd5, mk(1'b1, AAPL, 21'h00123));
        model(AAPL, 9'd5, eh, ed, ei, el);
        do_lookup(AAPL, 9'd5, h, d, i, l);
        checks++;
        if (h !== 1'b1 || d !== 21'h00123 || i !== 9'd5 || l != 3 || h !== eh || d !== ed || i !== ei || l != el) begin
            errors++;
            $display("FAIL basic_hit: hit=%b data=%h idx=%0d lat=%0d, want hit=1 data=00123 idx=5 lat=3", h, d, i, l);
        end
    endtask

    task automatic test_wrap();
        logic h, eh; logic [20:0] d, ed; logic [8:0] i, ei; int l, el;
        host_write(9'd510, mk(1'b1, MSFT, 21'h1));
        host_write(9'd511, mk(1'b1, GOOG, 21'h2));
        host_write(9'd0,   mk(1'b1, IBM,  21'h0ABCD));
        model(IBM, 9'd510, eh, ed, ei, el);
        do_lookup(IBM, 9'd510, h, d, i, l);
        checks++;
        if (h !== 1'b1 || i !== 9'd0 || l != 7 || d !== 21'h0ABCD || h !== eh || i !== ei || l != el) begin
            errors++;
            $display("FAIL wrap_hit: hit=%b data=%h idx=%0d lat=%0d, want hit=1 data=0abcd idx=0 lat=7", h, d, i, l);
        end
    endtask

    task automatic test_max_probe();
        logic h, eh; logic [20:0] d, ed; logic [8:0] i, ei; int l, el;
        host_write(9'd10, mk(1'b1, MSFT, 21'h10));
        host_write(9'd11, mk(1'b1, GOOG, 21'h11));
        host_write(9'd12, mk(1'b1, MSFT, 21'h12));
        host_write(9'd13, mk(1'b1, GOOG, 21'h13));
        host_write(9'd14, mk(1'b1, AAPL, 21'h14));
        model(AAPL, 9'd10, eh, ed, ei, el);
        do_lookup(AAPL, 9'd10, h, d, i, l);
        checks++;
        if (h !== 1'b0 || d !== 21'h0 || i !== 9'd13 || l != 2 * MAX_PROBE + 1 || h !== eh || i !== ei || l != el) begin
            errors++;
            $display("FAIL max_probe_miss: hit=%b data=%h idx=%0d lat=%0d, want hit=0 data=0 idx=13 lat=%0d",
                     h, d, i, l, 2 * MAX_PROBE + 1);
        end
    endtask

    task automatic test_empty_slot();
        logic h, eh; logic [20:0] d, ed; logic [8:0] i, ei; int l, el;
        host_write(9'd20, mk(1'b0, AAPL, 21'h55));
        host_write(9'd21, mk(1'b1, AAPL, 21'h66));
        model(AAPL, 9'd20, eh, ed, ei, el);
        do_lookup(AAPL, 9'd20, h, d, i, l);
        checks++;
        if (h !== 1'b0 || d !== 21'h0 || i !== 9'd20 || l != 3 || h !== eh || i !== ei || l != el) begin
            errors++;
            $display("FAIL empty_slot_miss: hit=%b data=%h idx=%0d lat=%0d, want hit=0 data=0 idx=20 lat=3", h, d, i, l);
        end
    endtask

    task automatic test_write_priority_and_hold();
        logic eh; logic [20:0] ed; logic [8:0] ei; int el;
        logic h; logic [20:0] d; logic [8:0] i; int l, n;
        logic [69:0] ent;
        logic stable;
        ent = mk(1'b1, GOOG, 21'h1F00D);
        host_wr_addr = 9'd40; host_wr_data = ent; host_wr_req = 1'b1;
        req_code = GOOG; req_hash = 9'd40; req_valid = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL prio_ready_low: req_ready=%b, want 0", req_ready);
        end
        @(negedge clk);
        checks++;
        if (host_wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 9'd40) begin
            errors++;
            $display("FAIL prio_write_first: ack=%b we=%b addr=%0d, want ack=1 we=1 addr=40", host_wr_ack, mem_we, mem_addr);
        end
        host_wr_req = 1'b0;
        shadow[40] = ent;
        n = 0;
        #1;
        while (!req_ready && n < 10) begin
            @(negedge clk); #1; n++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        l = 1;
        while (!rsp_valid && l < 40) begin
            @(negedge clk); l++;
        end
        h = rsp_hit; d = rsp_data; i = rsp_index;
        model(GOOG, 9'd40, eh, ed, ei, el);
        checks++;
        if (rsp_valid !== 1'b1 || h !== eh || d !== ed || i !== ei || l != el) begin
            errors++;
            $display("FAIL prio_lookup: valid=%b hit=%b data=%h idx=%0d lat=%0d, want valid=1 hit=%b data=%h idx=%0d lat=%0d",
                     rsp_valid, h, d, i, l, eh, ed, ei, el);
        end
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_hit !== h || rsp_data !== d || rsp_index !== i) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL rsp_hold_stable: valid=%b hit=%b data=%h idx=%0d, want 1 %b %h %0d",
                     rsp_valid, rsp_hit, rsp_data, rsp_index, h, d, i);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rsp_handshake: rsp_valid=%b req_ready=%b, want 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset_in_wait();
        int n;
        logic quiet;
        req_code = AAPL; req_hash = 9'd5; req_valid = 1'b1;
        #1;
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk); #1; n++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_wait_during: we=%b rsp_valid=%b ready=%b, want 0 0 0", mem_we, rsp_valid, req_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_wait_release: ready=%b rsp_valid=%b we=%b, want 1 0 0", req_ready, rsp_valid, mem_we);
        end
        quiet = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || mem_we !== 1'b0 || host_wr_ack !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL reset_wait_no_response: activity seen after abandoned lookup, want none");
        end
    endtask

    task automatic test_back_to_back();
        logic h, eh; logic [20:0] d, ed; logic [8:0] i, ei; int l, el;
        model(AAPL, 9'd5, eh, ed, ei, el);
        do_lookup(AAPL, 9'd5, h, d, i, l);
        checks++;
        if (h !== eh || d !== ed || i !== ei || l != el) begin
            errors++;
            $display("FAIL b2b_first: hit=%b data=%h idx=%0d lat=%0d, want %b %h %0d %0d", h, d, i, l, eh, ed, ei, el);
        end
        model(MSFT, 9'd11, eh, ed, ei, el);
        do_lookup(MSFT, 9'd11, h, d, i, l);
        checks++;
        if (h !== eh || d !== ed || i !== ei || l != el) begin
            errors++;
            $display("FAIL b2b_second: hit=%b data=%h idx=%0d lat=%0d, want %b %h %0d %0d", h, d, i, l, eh, ed, ei, el);
        end
    endtask

    task automatic test_random();
        logic [47:0] pool [4];
        logic h, eh; logic [20:0] d, ed; logic [8:0] i, ei; int l, el;
        pool[0] = AAPL; pool[1] = MSFT; pool[2] = GOOG; pool[3] = IBM;
        for (int k = 100; k < 132; k++)
            host_write(9'(k), mk($urandom_range(0, 9) < 8, pool[$urandom_range(0, 3)], 21'($urandom)));
        for (int k = 0; k < 24; k++) begin
            logic [47:0] c;
            logic [8:0] hh;
            c = pool[$urandom_range(0, 3)];
            hh = 9'($urandom_range(98, 133));
            model(c, hh, eh, ed, ei, el);
            do_lookup(c, hh, h, d, i, l);
            checks++;
            if (h !== eh || d !== ed || i !== ei || l != el) begin
                errors++;
                $display("FAIL random_lookup[%0d] hash=%0d: hit=%b data=%h idx=%0d lat=%0d, want %b %h %0d %0d",
                         k, hh, h, d, i, l, eh, ed, ei, el);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 512; k++) begin
            ram[k] = '0;
            shadow[k] = '0;
        end
        @(negedge clk);
        test_reset();
        test_basic_hit();
        test_wrap();
        test_max_probe();
        test_empty_slot();
        test_write_priority_and_hold();
        test_reset_in_wait();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stock_code_lookup.md
STOCK_CODE_LOOKUP -- requirements
Module: stock_code_lookup

Interface
REQ-001 SHALL have parameter MAX_PROBE, default 4: maximum table entries examined per lookup (1..8).
REQ-002 SHALL have port clk  in  1: single clock; all logic on rising edge.
REQ-003 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-004 SHALL have port req_valid  in  1: lookup request present.
REQ-005 SHALL have port req_ready  out  1: lookup request accepted when high with req_valid.
REQ-006 SHALL have port req_code  in  48: six-character ASCII stock code key.
REQ-007 SHALL have port req_hash  in  9: starting table index.
REQ-008 SHALL have port rsp_valid  out  1: response present.
REQ-009 SHALL have port rsp_ready  in  1: response consumed when high with rsp_valid.
REQ-010 SHALL have port rsp_hit  out  1: key found.
REQ-011 SHALL have port rsp_data  out  21: payload of the matching entry; 0 on miss.
REQ-012 SHALL have port rsp_index  out  9: index of the matching entry, or the last index probed on miss.
REQ-013 SHALL have port host_wr_req  in  1: host table-write request, level held until ack.
REQ-014 SHALL have port host_wr_addr  in  9: host write index.
REQ-015 SHALL have port host_wr_data  in  70: host write entry.
REQ-016 SHALL have port host_wr_ack  out  1: one-cycle pulse on the write cycle.
REQ-017 SHALL have port mem_addr  out  9: table RAM address, registered.
REQ-018 SHALL have port mem_din  out  70: table RAM write data, registered.
REQ-019 SHALL have port mem_we  out  1: table RAM write enable, registered.
REQ-020 SHALL have port mem_dout  in  70: table RAM read data, valid one cycle after mem_addr is presented with mem_we low.

Function
REQ-021 SHALL use the entry format: bit 69 = valid, bits 68:21 = code, bits 20:0 = payload.
REQ-022 SHALL implement states IDLE, WAIT, CMP, RESP and WRITE.
REQ-023 SHALL drive req_ready high only in IDLE with host_wr_req low.
REQ-024 In IDLE with host_wr_req high, SHALL go to WRITE; host writes take priority over lookups.
REQ-025 In WRITE, SHALL assert mem_we for exactly one cycle with mem_addr=host_wr_addr and mem_din=host_wr_data, pulse host_wr_ack in that same cycle, then return to IDLE.
REQ-026 On lookup accept, SHALL latch code and hash, set probe count to 0, set mem_addr=req_hash, and go to WAIT.
REQ-027 WAIT SHALL last one cycle, then go to CMP.
REQ-028 In CMP, when valid=1 and code matches, SHALL go to RESP with rsp_hit=1, rsp_data=payload and rsp_index=mem_addr.
REQ-029 In CMP, when valid=0, SHALL go to RESP with a miss; an empty slot terminates the probe chain.
REQ-030 In CMP, on mismatch with probe count = MAX_PROBE-1, SHALL go to RESP with a miss.
REQ-031 In CMP, on mismatch otherwise, SHALL increment the probe count, set mem_addr=(hash+probe) mod 512 (wrapping 511 to 0), and go to WAIT.
REQ-032 SHALL assert rsp_valid exactly 3 cycles after the accept edge for a first-probe result; each additional probe SHALL add 2 cycles.
REQ-033 In RESP, SHALL hold rsp_* stable until rsp_ready; on the handshake cycle SHALL deassert rsp_valid and return to IDLE.
REQ-034 SHALL ignore host_wr_req outside IDLE; the request is serviced on the first IDLE cycle after the lookup completes.
REQ-035 SHALL hold mem_we low in all states except WRITE.

Reset
REQ-036 While reset is high, SHALL force state to IDLE and drive rsp_valid, rsp_hit, rsp_data, rsp_index, host_wr_ack, mem_we, mem_addr, mem_din and req_ready to 0.
REQ-037 Reset during any state SHALL abandon the operation, produce no response and no ack, and leave req_ready high on the first cycle after reset deasserts.

Verification
REQ-038 Host writes {1, "AAPL  ", 21'h00123} at index 5, then looks up hash=5 -> rsp_hit=1, rsp_data=21'h00123, rsp_index=5, rsp_valid 3 cycles after accept.
REQ-039 Entries at 510 and 511 mismatch; key stored at 0; lookup with hash=510 -> hit, rsp_index=0, rsp_valid 7 cycles after accept.
REQ-040 Four valid mismatching entries at 10..13 with MAX_PROBE=4, lookup hash=10 -> rsp_hit=0, rsp_data=0, rsp_index=13.
REQ-041 Entry at 20 valid=0, lookup hash=20 -> miss after 1 probe, rsp_index=20.
REQ-042 host_wr_req and req_valid asserted together in IDLE -> write acked first, req_ready low that cycle, lookup accepted next IDLE; rsp_ready held low for 5 cycles -> rsp_* stable throughout.
REQ-043 Reset asserted in WAIT -> no rsp_valid, mem_we=0, req_ready=1 one cycle after reset release.
